link_test_controller: RTL and testbench
=======================================

Name: link_test_controller

Overview:
- Parametrised traffic generator and loopback checker for the Encoder/Decoder pulse link.
- Replaces the ad-hoc button/continuous launch logic at the board top with one block.
- Adds four launch modes (manual, continuous, incrementing pattern, burst) and a runtime-programmable inter-packet gap.
- Checks every received packet against the one sent and keeps sent, match, mismatch and lost counters for LED/HEX display.

Parameters:
N_PKT, 8, packet payload width in bits
GAP_W, 32, width of gap_cycles and of the gap counter
TIMEOUT, 1_000_000, cycles to wait in WAIT_RX before declaring a packet lost (must be ≥2)
BURST_LEN, 16, packets sent per trigger in BURST mode (≥1)
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
mode  input  2  00 MANUAL, 01 CONTINUOUS, 10 PATTERN, 11 BURST
enable  input  1  run enable for CONTINUOUS/PATTERN
send_req  input  1  level request (debounced button, active-high); rising edge = trigger
sw_data  input  N_PKT  payload for MANUAL/CONTINUOUS
gap_cycles  input  GAP_W  idle cycles inserted after each completed packet
clear_stats  input  1  synchronous clear of statistics counters
enc_avail  input  1  encoder idle and able to accept a packet
tx_start  output  1  one-cycle launch strobe to encoder
tx_data  output  N_PKT  payload to encoder; held stable until the next launch
rx_avail  input  1  decoder one-cycle strobe: rx_data valid
rx_data  input  N_PKT  decoded payload
busy  output  1  high in every state except IDLE
last_rx  output  N_PKT  most recent rx_data captured on rx_avail
tx_count, ok_count, err_count, lost_count  output  CNT_W each  statistics

Behaviour:
- Reset (rst high at clk edge): state IDLE; tx_start=0, tx_data=0, busy=0, last_rx=0, all counters 0, pattern register 0, burst remaining 0, pending flag 0, send_req edge-detect register 0.
- Trigger: rising edge of send_req, taken from a registered previous value, sets pending flag; pending is cleared when the packet it requested is launched.
- Launch condition, evaluated only in IDLE:
  - MANUAL: pending.
  - CONTINUOUS/PATTERN: enable.
  - BURST: burst_remaining>0, or pending (loads burst_remaining=BURST_LEN).
  - In all modes, launch also requires enc_avail=1.
- mode is sampled only in IDLE; a mode change mid-transaction takes effect at the next IDLE.
- FSM states IDLE, SEND, WAIT_RX, GAP:
  - IDLE -> SEND when launch condition is true.
  - SEND: tx_start=1 for exactly this cycle. tx_data and expected register load the payload on the IDLE->SEND edge, so tx_data is valid in the cycle tx_start is high. tx_count++. PATTERN/BURST post-increment the pattern register (wraps 2^N_PKT-1 -> 0); BURST decrements burst_remaining. Always -> WAIT_RX.
  - WAIT_RX, timeout counter cleared on entry:
    - rx_avail=1: ok_count++ if rx_data==expected, else err_count++; -> GAP.
    - Otherwise, TIMEOUT cycles after entry: lost_count++; -> GAP.
    - rx_avail and timeout in the same cycle: the receive wins and no loss is counted.
  - GAP: gap counter cleared on entry; -> IDLE after gap_cycles cycles in GAP. gap_cycles=0 means exactly one GAP cycle. gap_cycles is sampled on GAP entry.
- Payload source: MANUAL/CONTINUOUS use sw_data; PATTERN/BURST use the pattern register.
- rx_avail outside WAIT_RX (stray packet): err_count++; state unaffected.
- last_rx updates on every rx_avail, in any state.
- Counters saturate at 2^CNT_W-1.
- clear_stats zeroes all four counters and last_rx; it overrides a same-cycle increment and does not affect the FSM.
- enable falling mid-transaction: the current packet completes through GAP, then the block stays in IDLE.
- Triggers arriving while busy set pending, so at most one queued manual request is honoured.
- enc_avail low in IDLE: wait; no timeout runs in IDLE.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0, busy=0. MANUAL, sw_data=0xA5, enc_avail=1, pulse send_req; decoder model echoes 0xA5 after 50 cycles -> exactly one tx_start with tx_data=0xA5; tx_count=1, ok_count=1, last_rx=0xA5, busy low after 1+gap cycles.
- CONTINUOUS, gap_cycles=10, enable high for 1000 cycles, echo latency 20 -> tx_start period exactly 1+20+1+10 cycles (SEND + WAIT_RX + GAP); ok_count==tx_count; drop enable mid-WAIT_RX -> in-flight packet still counted, no further launches.
- PATTERN for 260 packets -> tx_data sequence 0x00..0xFF,0x00..0x03 (wrap); a model corrupting packet 7 -> err_count=1, ok_count=259.
- BURST, BURST_LEN=16, single trigger -> exactly 16 launches of 0x00..0x0F, then IDLE with burst_remaining=0; a second trigger mid-burst is queued and starts a new 16-packet burst.
- TIMEOUT=100, no echo -> lost_count=1 exactly 100 cycles after WAIT_RX entry. rx_avail on the timeout cycle -> ok/err incremented, lost unchanged. Stray rx_avail in IDLE -> err_count++.
- CNT_W=4, 20 launches -> tx_count holds 15. clear_stats asserted together with an rx_avail -> counters 0. rst asserted during WAIT_RX -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/link_test_controller.sv
// link_test_controller: traffic generator and loopback checker for the
// Encoder/Decoder pulse link. Launches packets in one of four modes, waits
// for the echo, and keeps saturating sent/ok/error/lost counters.
module link_test_controller #(
  parameter int N_PKT     = 8,
  parameter int GAP_W     = 32,
  parameter int TIMEOUT   = 1_000_000,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             enable,
  input  logic             send_req,
  input  logic [N_PKT-1:0] sw_data,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             clear_stats,
  input  logic             enc_avail,
  output logic             tx_start,
  output logic [N_PKT-1:0] tx_data,
  input  logic             rx_avail,
  input  logic [N_PKT-1:0] rx_data,
  output logic             busy,
  output logic [N_PKT-1:0] last_rx,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] lost_count
);

  localparam logic [1:0] S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2, S_GAP = 2'd3;
  localparam logic [1:0] M_MAN = 2'd0, M_CONT = 2'd1, M_PAT = 2'd2, M_BURST = 2'd3;
  localparam int TO_W = $clog2(TIMEOUT);
  localparam int BR_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;          // mode latched at launch
  logic [N_PKT-1:0] tx_data_q, tx_data_d;
  logic [N_PKT-1:0] exp_q, exp_d;            // payload the echo must match
  logic [N_PKT-1:0] pat_q, pat_d;
  logic [N_PKT-1:0] last_rx_q, last_rx_d;
  logic [BR_W-1:0]  burst_q, burst_d;
  logic             pend_q, pend_d;
  logic             req_prev_q;
  logic [TO_W-1:0]  to_q, to_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, lost_cnt_q, lost_cnt_d;

  logic             launch, inc_tx, inc_ok, inc_err, inc_lost;
  logic [N_PKT-1:0] src;
  logic [GAP_W:0]   gap_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // Next-state logic: FSM, payload selection, pending/burst bookkeeping, stats
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_data_d = tx_data_q;
    exp_d     = exp_q;
    pat_d     = pat_q;
    last_rx_d = last_rx_q;
    burst_d   = burst_q;
    pend_d    = pend_q;
    to_d      = to_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    launch    = 1'b0;
    inc_tx    = 1'b0;
    inc_ok    = 1'b0;
    inc_err   = 1'b0;
    inc_lost  = 1'b0;
    src       = sw_data;
    gap_nxt   = {1'b0, gap_cnt_q} + {{GAP_W{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        case (mode)
          M_MAN:         launch = pend_q;
          M_CONT, M_PAT: launch = enable;
          default:       launch = (burst_q != '0) || pend_q;
        endcase
        launch = launch & enc_avail;
        if (mode == M_PAT || mode == M_BURST) src = pat_q;
        if (launch) begin
          state_d   = S_SEND;
          mode_d    = mode;
          tx_data_d = src;
          exp_d     = src;
          if (mode == M_MAN) pend_d = 1'b0;
          // a queued burst trigger only starts once the running burst is done
          if (mode == M_BURST && burst_q == '0) begin
            burst_d = BR_W'(BURST_LEN);
            pend_d  = 1'b0;
          end
        end
      end
      S_SEND: begin
        inc_tx = 1'b1;
        if (mode_q == M_PAT || mode_q == M_BURST) pat_d = pat_q + N_PKT'(1);
        if (mode_q == M_BURST) burst_d = burst_q - BR_W'(1);
        to_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a receive on the timeout cycle takes precedence over the loss
        if (rx_avail) begin
          if (rx_data == exp_q) inc_ok = 1'b1;
          else                  inc_err = 1'b1;
          state_d = S_GAP;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          inc_lost = 1'b1;
          state_d  = S_GAP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
        if (state_d == S_GAP) begin
          gap_cnt_d = '0;
          gap_len_d = gap_cycles;
        end
      end
      default: begin
        // gap_cycles of zero still spends one cycle here
        if (gap_nxt >= {1'b0, gap_len_q}) state_d = S_IDLE;
        else                              gap_cnt_d = gap_nxt[GAP_W-1:0];
      end
    endcase

    if (rx_avail && state_q != S_WAIT) inc_err = 1'b1;
    if (rx_avail) last_rx_d = rx_data;
    if (send_req && !req_prev_q) pend_d = 1'b1;

    tx_cnt_d   = sat_inc(tx_cnt_q, inc_tx);
    ok_cnt_d   = sat_inc(ok_cnt_q, inc_ok);
    err_cnt_d  = sat_inc(err_cnt_q, inc_err);
    lost_cnt_d = sat_inc(lost_cnt_q, inc_lost);
    if (clear_stats) begin
      tx_cnt_d   = '0;
      ok_cnt_d   = '0;
      err_cnt_d  = '0;
      lost_cnt_d = '0;
      last_rx_d  = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= M_MAN;
      tx_data_q  <= '0;
      exp_q      <= '0;
      pat_q      <= '0;
      last_rx_q  <= '0;
      burst_q    <= '0;
      pend_q     <= 1'b0;
      req_prev_q <= 1'b0;
      to_q       <= '0;
      gap_len_q  <= '0;
      gap_cnt_q  <= '0;
      tx_cnt_q   <= '0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_data_q  <= tx_data_d;
      exp_q      <= exp_d;
      pat_q      <= pat_d;
      last_rx_q  <= last_rx_d;
      burst_q    <= burst_d;
      pend_q     <= pend_d;
      req_prev_q <= send_req;
      to_q       <= to_d;
      gap_len_q  <= gap_len_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign tx_start   = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE);
  assign tx_data    = tx_data_q;
  assign last_rx    = last_rx_q;
  assign tx_count   = tx_cnt_q;
  assign ok_count   = ok_cnt_q;
  assign err_count  = err_cnt_q;
  assign lost_count = lost_cnt_q;

endmodule

// File: tb/tb_link_test_controller.sv
// Bench for link_test_controller: scoreboard of expected launch payloads,
// a decoder echo model with optional corruption, and phase-level count checks.
module tb_link_test_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, send_req, clear_stats, enc_avail, rx_avail;
  logic [1:0]  mode;
  logic [7:0]  sw_data, rx_data;
  logic [31:0] gap_cycles;
  logic        tx_start, busy;
  logic [7:0]  tx_data, last_rx;
  logic [15:0] tx_count, ok_count, err_count, lost_count;
  logic        tx_start4, busy4;
  logic [7:0]  tx_data4, last_rx4;
  logic [3:0]  txc4, okc4, errc4, lostc4;

  link_test_controller #(.N_PKT(8), .GAP_W(32), .TIMEOUT(100), .BURST_LEN(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .enable(enable), .send_req(send_req),
    .sw_data(sw_data), .gap_cycles(gap_cycles), .clear_stats(clear_stats),
    .enc_avail(enc_avail), .tx_start(tx_start), .tx_data(tx_data),
    .rx_avail(rx_avail), .rx_data(rx_data), .busy(busy), .last_rx(last_rx),
    .tx_count(tx_count), .ok_count(ok_count), .err_count(err_count), .lost_count(lost_count));

  // narrow-counter copy sharing all inputs, for saturation
  link_test_controller #(.N_PKT(8), .GAP_W(32), .TIMEOUT(100), .BURST_LEN(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .enable(enable), .send_req(send_req),
    .sw_data(sw_data), .gap_cycles(gap_cycles), .clear_stats(clear_stats),
    .enc_avail(enc_avail), .tx_start(tx_start4), .tx_data(tx_data4),
    .rx_avail(rx_avail), .rx_data(rx_data), .busy(busy4), .last_rx(last_rx4),
    .tx_count(txc4), .ok_count(okc4), .err_count(errc4), .lost_count(lostc4));

  int checks = 0, fails = 0;
  int cyc = 0, n_tx = 0, last_tx_cyc = -1;
  logic [7:0] exp_q[$];
  bit   echo_on = 1'b0, echo_pend = 1'b0, period_on = 1'b0;
  int   echo_lat = 1, echo_t = 0, corrupt_at = -1, per_exp = 0;
  logic [7:0] echo_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // one clock; sample outputs and drive decoder model on the falling edge
  task automatic step();
    @(negedge clk);
    cyc++;
    rx_avail = 1'b0;
    if (tx_start) begin
      if (period_on && last_tx_cyc >= 0) chk("period", 64'(cyc - last_tx_cyc), 64'(per_exp));
      last_tx_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_launch", 1, 0);
      else chk("tx_data", 64'(tx_data), 64'(exp_q.pop_front()));
      if (echo_on) begin
        echo_pend = 1'b1;
        echo_t    = cyc + echo_lat;
        echo_d    = (n_tx == corrupt_at) ? ~tx_data : tx_data;
      end
      n_tx++;
    end
    if (echo_pend && cyc == echo_t) begin
      rx_avail  = 1'b1;
      rx_data   = echo_d;
      echo_pend = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int g = 0;
    while (n_tx < target && g < budget) begin step(); g++; end
    if (n_tx < target) chk(tag, 64'(n_tx), 64'(target));
  endtask

  task automatic pulse_req();
    send_req = 1'b1; step(); send_req = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_start"}, 64'(tx_start), 0);
    chk({tag, "_tx_data"},  64'(tx_data), 0);
    chk({tag, "_busy"},     64'(busy), 0);
    chk({tag, "_last_rx"},  64'(last_rx), 0);
    chk({tag, "_counts"},   {tx_count, ok_count, err_count, lost_count}, 0);
    chk({tag, "_dut4"},     64'({tx_start4, busy4, tx_data4, last_rx4, txc4, okc4, errc4, lostc4}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, s;
    rst = 1'b1; enable = 1'b0; send_req = 1'b0; clear_stats = 1'b0; enc_avail = 1'b1;
    rx_avail = 1'b0; rx_data = '0; mode = 2'd0; sw_data = '0; gap_cycles = '0;
    run(2);
    chk_reset("reset");
    rst = 1'b0;

    // MANUAL single packet
    mode = 2'd0; sw_data = 8'hA5; gap_cycles = 3; echo_on = 1'b1; echo_lat = 50;
    exp_q.push_back(8'hA5);
    pulse_req();
    run(80);
    chk("man_ntx", 64'(n_tx), 1);
    chk("man_tx_count", 64'(tx_count), 1);
    chk("man_ok", 64'(ok_count), 1);
    chk("man_last_rx", 64'(last_rx), 64'hA5);
    chk("man_busy", 64'(busy), 0);

    // CONTINUOUS with period check, enable dropped mid-WAIT_RX
    mode = 2'd1; sw_data = 8'h3C; gap_cycles = 10; echo_lat = 20;
    for (int i = 0; i < 30; i++) exp_q.push_back(8'h3C);
    period_on = 1'b1; per_exp = 32; last_tx_cyc = -1;
    enable = 1'b1;
    wait_tx(31, 1100, "cont_timeout");
    run(5);
    enable = 1'b0;
    run(60);
    period_on = 1'b0;
    chk("cont_ntx", 64'(n_tx), 31);
    chk("cont_tx_count", 64'(tx_count), 31);
    chk("cont_ok", 64'(ok_count), 31);
    chk("cont_queue", 64'(exp_q.size()), 0);
    chk("cont_busy", 64'(busy), 0);

    // PATTERN 260 packets with wrap, packet 7 corrupted
    mode = 2'd2; gap_cycles = 0; echo_lat = 3; n0 = n_tx; corrupt_at = n0 + 7;
    for (int i = 0; i < 260; i++) exp_q.push_back(8'(i));
    period_on = 1'b1; per_exp = 6; last_tx_cyc = -1;
    enable = 1'b1;
    wait_tx(n0 + 260, 1700, "pat_timeout");
    enable = 1'b0;
    run(20);
    period_on = 1'b0; corrupt_at = -1;
    chk("pat_err", 64'(err_count), 1);
    chk("pat_ok", 64'(ok_count), 290);
    chk("pat_tx_count", 64'(tx_count), 291);
    chk("pat_queue", 64'(exp_q.size()), 0);

    // reset, then BURST with a second trigger queued mid-burst
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset("reset2");
    mode = 2'd3; gap_cycles = 2; echo_lat = 4; n0 = n_tx;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    pulse_req();
    wait_tx(n0 + 5, 100, "burst_start_timeout");
    for (int i = 16; i < 32; i++) exp_q.push_back(8'(i));
    pulse_req();
    wait_tx(n0 + 32, 600, "burst_timeout");
    run(40);
    chk("burst_ntx", 64'(n_tx - n0), 32);
    chk("burst_tx_count", 64'(tx_count), 32);
    chk("burst_ok", 64'(ok_count), 32);
    chk("burst_busy", 64'(busy), 0);
    chk("burst_queue", 64'(exp_q.size()), 0);
    chk("sat_tx4", 64'(txc4), 15);
    chk("sat_ok4", 64'(okc4), 15);

    // TIMEOUT: no echo, loss exactly 100 cycles after WAIT_RX entry
    mode = 2'd0; echo_on = 1'b0; sw_data = 8'h11; n0 = n_tx;
    exp_q.push_back(8'h11);
    pulse_req();
    wait_tx(n0 + 1, 20, "to_launch_timeout");
    s = last_tx_cyc;
    while (cyc < s + 100) step();
    chk("lost_early", 64'(lost_count), 0);
    step();
    chk("lost_on_time", 64'(lost_count), 1);
    run(10);

    // echo lands on the timeout cycle: receive wins
    echo_on = 1'b1; echo_lat = 100; sw_data = 8'h22; n0 = n_tx;
    exp_q.push_back(8'h22);
    pulse_req();
    wait_tx(n0 + 1, 20, "to2_launch_timeout");
    run(110);
    chk("to_rx_ok", 64'(ok_count), 33);
    chk("to_rx_lost", 64'(lost_count), 1);
    chk("to_rx_err", 64'(err_count), 0);

    // stray receive in IDLE
    run(2);
    rx_avail = 1'b1; rx_data = 8'h77;
    step();
    chk("stray_err", 64'(err_count), 1);
    chk("stray_last_rx", 64'(last_rx), 64'h77);
    chk("stray_busy", 64'(busy), 0);

    // clear_stats wins over a same-cycle receive
    clear_stats = 1'b1; rx_avail = 1'b1; rx_data = 8'h55;
    step();
    clear_stats = 1'b0;
    chk("clr_counts", {tx_count, ok_count, err_count, lost_count}, 0);
    chk("clr_last_rx", 64'(last_rx), 0);

    // reset while waiting for the echo
    echo_on = 1'b0; sw_data = 8'h99; n0 = n_tx;
    exp_q.push_back(8'h99);
    pulse_req();
    wait_tx(n0 + 1, 20, "rstw_launch_timeout");
    run(3);
    chk("rstw_busy_before", 64'(busy), 1);
    rst = 1'b1; step();
    chk_reset("rst_wait");
    rst = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
